writeback_arbiter: RTL

WRITEBACK_ARBITER -- requirements
Module: writeback_arbiter

---
 rtl/writeback_arbiter.sv | 100 ++++++++++
 1 files changed

// File: rtl/writeback_arbiter.sv
// Writeback port arbiter: the main pipeline has priority, while late loads and quantum results share the leftover slots round-robin.
// A starvation counter forces a pipeline stall so that waiting side requesters are eventually served.
module writeback_arbiter #(
   parameter int unsigned STARVE_LIMIT = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        pipe_valid,
   input  logic [4:0]  pipe_rd,
   input  logic [31:0] pipe_data,
   output logic        pipe_stall,
   input  logic        ld_valid,
   input  logic [4:0]  ld_rd,
   input  logic [31:0] ld_data,
   output logic        ld_ready,
   input  logic        q_valid,
   input  logic [4:0]  q_rd,
   input  logic [31:0] q_data,
   output logic        q_ready,
   output logic        rf_we,
   output logic [4:0]  rf_waddr,
   output logic [31:0] rf_wdata
);

   localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

   typedef enum logic {SIDE_LD, SIDE_Q} side_t;

   side_t       last_side, last_next;
   logic [3:0]  wait_cnt, wait_next;
   logic        pipe_gnt, ld_gnt, q_gnt, any_gnt;
   logic [4:0]  gnt_rd;
   logic [31:0] gnt_data;

   // State register: arbitration state plus the registered register-file write port.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wait_cnt  <= 4'd0;
         last_side <= SIDE_Q;
         rf_we     <= 1'b0;
         rf_waddr  <= 5'd0;
         rf_wdata  <= 32'd0;
      end else begin
         wait_cnt  <= wait_next;
         last_side <= last_next;
         rf_we     <= any_gnt && (gnt_rd != 5'd0);
         if (any_gnt) begin
            rf_waddr <= gnt_rd;
            rf_wdata <= gnt_data;
         end
      end
   end

   // Next state: the counter tracks how many pipeline grants a side request has sat through.
   always_comb begin
      wait_next = wait_cnt;
      last_next = last_side;
      if (ld_gnt || q_gnt) begin
         wait_next = 4'd0;
         last_next = ld_gnt ? SIDE_LD : SIDE_Q;
      end else if (!ld_valid && !q_valid) begin
         wait_next = 4'd0;
      end else if (pipe_gnt && (wait_cnt != LIMIT)) begin
         wait_next = wait_cnt + 4'd1;
      end
   end

   // Grant decode: during reset nothing is consumed, whatever the inputs.
   always_comb begin
      pipe_stall = (wait_cnt == LIMIT);
      pipe_gnt   = !rst && pipe_valid && !pipe_stall;
      ld_gnt     = 1'b0;
      q_gnt      = 1'b0;
      if (!rst && !pipe_gnt) begin
         if (ld_valid && q_valid) begin
            ld_gnt = (last_side == SIDE_Q);
            q_gnt  = (last_side == SIDE_LD);
         end else begin
            ld_gnt = ld_valid;
            q_gnt  = q_valid;
         end
      end
      ld_ready = ld_gnt;
      q_ready  = q_gnt;
      any_gnt  = pipe_gnt || ld_gnt || q_gnt;
      gnt_rd   = 5'd0;
      gnt_data = 32'd0;
      if (pipe_gnt) begin
         gnt_rd   = pipe_rd;
         gnt_data = pipe_data;
      end else if (ld_gnt) begin
         gnt_rd   = ld_rd;
         gnt_data = ld_data;
      end else if (q_gnt) begin
         gnt_rd   = q_rd;
         gnt_data = q_data;
      end
   end

endmodule
